// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive port: default register addresses,
// CON register bit positions and the receive shifter state encoding.
package uart_pkg;

    localparam logic [31:0] RXD_ADDR_DEF = 32'h4000_001C;
    localparam logic [31:0] CON_ADDR_DEF = 32'h4000_0020;

    localparam int unsigned CON_VALID = 0;
    localparam int unsigned CON_OVR   = 1;
    localparam int unsigned CON_FERR  = 2;
    localparam int unsigned CON_IE    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_shifter.sv
// 8N1 deserializer: two-flop input synchronizer, bit-timing counter and
// receive FSM. Emits one-cycle byte_valid / frame_err pulses.
module uart_rx_shifter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_pulse_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // Edge detection and START entry each take a cycle, so stopping two short
    // of half a bit puts the start-bit check half a bit after rx_s fell.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);

    logic sync1_q, rx_s_q;
    logic warm_q, armed_q;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             ferr_q, ferr_d;

    // armed_q only rises once the line has been seen high after reset, so a
    // line that is already low when reset releases cannot fake a start bit.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            warm_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
            warm_q  <= 1'b1;
            armed_q <= armed_q | (warm_q & sync1_q);
        end
    end

    // NOTE: state registers take only non-blocking assignments; all next-state
    // decisions live in the combinational block below.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            ferr_q       <= ferr_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        ferr_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (armed_q && !rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        byte_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_valid_o      = byte_valid_q;
    assign byte_data_o       = shift_q;
    assign frame_err_pulse_o = ferr_q;

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped UART receiver: RXD/CON registers, receive buffer and IRQ.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise one holding register.
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [31:0] RXD_ADDR     = RXD_ADDR_DEF,
    parameter logic [31:0] CON_ADDR     = CON_ADDR_DEF
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        UART_RX,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rx_irq
);

    logic       byte_valid, frame_err_pulse;
    logic [7:0] byte_data;
    logic       rx_valid, full;
    logic [7:0] head;
    logic       rxd_hit, con_hit, pop, con_wr, push_ok, overrun_evt;
    logic       overrun_q, overrun_d, frame_err_q, frame_err_d, irq_en_q, irq_en_d;
    logic       unused_wdata;

    uart_rx_shifter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_shifter (
        .sysclk            (sysclk),
        .reset             (reset),
        .rx_i              (UART_RX),
        .byte_valid_o      (byte_valid),
        .byte_data_o       (byte_data),
        .frame_err_pulse_o (frame_err_pulse)
    );

    assign rxd_hit = (addr == RXD_ADDR);
    assign con_hit = (addr == CON_ADDR);
    assign pop     = rd & rxd_hit & rx_valid;
    assign con_wr  = wr & con_hit;

    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign push_ok     = byte_valid & (~full | pop);
    assign overrun_evt = byte_valid & full & ~pop;

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wptr_q, rptr_q;
    logic [2:0] cnt_q;

    assign rx_valid = (cnt_q != 3'd0);
    assign full     = (cnt_q == 3'd4);
    assign head     = mem_q[rptr_q];

    // NOTE: the storage array has no reset; pointers and count alone decide
    // which entries are meaningful.
    always_ff @(posedge sysclk) begin
        if (push_ok) mem_q[wptr_q] <= byte_data;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 2'd1;
            if (pop)     rptr_q <= rptr_q + 2'd1;
            cnt_q <= cnt_q + {2'b00, push_ok} - {2'b00, pop};
        end
    end
`else
    logic [7:0] hold_q;
    logic       hold_vld_q;

    assign rx_valid = hold_vld_q;
    assign full     = hold_vld_q;
    assign head     = hold_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (push_ok) begin
            hold_q     <= byte_data;
            hold_vld_q <= 1'b1;
        end else if (pop) begin
            hold_vld_q <= 1'b0;
        end
    end
`endif

    // Clears are applied first so a flag set on the same edge survives.
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        irq_en_d    = irq_en_q;
        if (con_wr) begin
            if (wdata[CON_OVR])  overrun_d   = 1'b0;
            if (wdata[CON_FERR]) frame_err_d = 1'b0;
            irq_en_d = wdata[CON_IE];
        end
        if (overrun_evt)     overrun_d   = 1'b1;
        if (frame_err_pulse) frame_err_d = 1'b1;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_en_q    <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_en_q    <= irq_en_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && rxd_hit && rx_valid) begin
            rdata[7:0] = head;
        end else if (rd && con_hit) begin
            rdata[CON_VALID] = rx_valid;
            rdata[CON_OVR]   = overrun_q;
            rdata[CON_FERR]  = frame_err_q;
            rdata[CON_IE]    = irq_en_q;
        end
    end

    assign rx_irq = irq_en_q & rx_valid;

    // Bit 0 of CON is read-only and the upper write bits have no meaning.
    assign unused_wdata = ^{wdata[31:4], wdata[0]};

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port with a queue-based reference model that is
// compared against rdata/rx_irq on every cycle.
module tb_uart_rx_port;

    localparam int CPB = 16;
    localparam int LAT = 2 + (19 * CPB) / 2 + 1;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        sysclk  = 1'b0;
    logic        reset   = 1'b0;
    logic        UART_RX = 1'b1;
    logic        rd      = 1'b0;
    logic        wr      = 1'b0;
    logic [31:0] addr    = '0;
    logic [31:0] wdata   = '0;
    logic [31:0] rdata;
    logic        rx_irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    uart_rx_port #(.CLKS_PER_BIT(CPB)) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .UART_RX (UART_RX),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rx_irq  (rx_irq)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte queue of bounded depth plus three flags.
    typedef struct {
        int         due;
        logic [7:0] data;
        bit         ok;
    } frame_t;

    frame_t     pend[$];
    logic [7:0] m_q[$];
    bit         m_ovr = 1'b0, m_ferr = 1'b0, m_ie = 1'b0;

    always @(posedge sysclk or negedge reset) begin
        int now;
        if (!reset) begin
            m_q.delete();
            pend.delete();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            m_ie   = 1'b0;
        end else begin
            now = cyc + 1;
            if (rd && addr == RXD && m_q.size() != 0) void'(m_q.pop_front());
            if (wr && addr == CON) begin
                m_ie = wdata[3];
                if (wdata[1]) m_ovr = 1'b0;
                if (wdata[2]) m_ferr = 1'b0;
            end
            if (pend.size() != 0 && pend[0].due == now) begin
                if (!pend[0].ok)              m_ferr = 1'b1;
                else if (m_q.size() < DEPTH)  m_q.push_back(pend[0].data);
                else                          m_ovr = 1'b1;
                void'(pend.pop_front());
            end
        end
    end

    always @(negedge sysclk) begin
        logic [31:0] exp_rd;
        bit          m_valid;
        m_valid = (m_q.size() != 0);
        exp_rd  = '0;
        if (rd && addr == RXD && m_valid) exp_rd = {24'h0, m_q[0]};
        else if (rd && addr == CON)       exp_rd = {28'h0, m_ie, m_ferr, m_ovr, m_valid};
        check("model_rdata", rdata, exp_rd);
        check("model_irq", {31'h0, rx_irq}, {31'h0, m_ie & m_valid});
    end

    // Tasks start at a rising edge and end on one; drives land 1 time unit later.
    task automatic drive_line(input logic v, input int n);
        #1 UART_RX = v;
        repeat (n) @(posedge sysclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        frame_t     f;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            #1 UART_RX = bits[i];
            if (i == 0) begin
                f.due  = cyc + LAT;
                f.data = d;
                f.ok   = stop;
                pend.push_back(f);
            end
            repeat (CPB) @(posedge sysclk);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        #1 rd = 1'b1; addr = a;
        @(negedge sysclk) d = rdata;
        @(posedge sysclk);
        #1 rd = 1'b0; addr = '0;
        @(posedge sysclk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        #1 wr = 1'b1; addr = a; wdata = d;
        @(posedge sysclk);
        #1 wr = 1'b0; addr = '0; wdata = '0;
        @(posedge sysclk);
    endtask

    task automatic expect_irq(input string name, input logic e);
        @(negedge sysclk) check(name, {31'h0, rx_irq}, {31'h0, e});
        @(posedge sysclk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  a_bytes [5];
        logic [7:0]  b_bytes [5];
        a_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        b_bytes = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};

        // Reset state, including a CON read while reset is held.
        rd = 1'b1; addr = CON;
        repeat (2) @(negedge sysclk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", {31'h0, rx_irq}, 32'h0);
        rd = 1'b0; addr = '0;
        @(posedge sysclk);
        #1 reset = 1'b1;
        repeat (4) @(posedge sysclk);

        bus_read(RXD, r);
        check("rxd_empty", r, 32'h0);

        // Single frame with exact rx_valid latency.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge UART_RX);
                rd = 1'b1; addr = CON;
                repeat (LAT - 1) @(posedge sysclk);
                @(negedge sysclk) check("valid_before_lat", rdata, 32'h0);
                @(negedge sysclk) check("valid_at_lat", rdata, 32'h1);
                #1 rd = 1'b0; addr = '0;
            end
        join
        bus_write(RXD, 32'hFF);
        bus_read(CON, r);  check("single_con", r, 32'h1);
        bus_read(RXD, r);  check("single_rxd", r, 32'hA5);
        bus_read(CON, r);  check("single_con_after", r, 32'h0);

        // Overrun: one more byte than the buffer holds, nothing read.
        for (int i = 0; i <= DEPTH; i++) send_frame(a_bytes[i], 1'b1);
        bus_read(CON, r);  check("ovr_con", r, 32'h3);
        for (int i = 0; i < DEPTH; i++) begin
            bus_read(RXD, r);
            check("ovr_rxd_order", r, {24'h0, a_bytes[i]});
        end
        bus_read(CON, r);  check("ovr_con_drained", r, 32'h2);
        bus_write(CON, 32'h2);
        bus_read(CON, r);  check("ovr_cleared", r, 32'h0);

        // Full buffer, pop on the same edge as the push: no overrun.
        for (int i = 0; i < DEPTH; i++) send_frame(b_bytes[i], 1'b1);
        fork
            send_frame(b_bytes[DEPTH], 1'b1);
            begin
                logic [31:0] rr;
                @(negedge UART_RX);
                repeat (LAT - 1) @(posedge sysclk);
                bus_read(RXD, rr);
                check("pop_push_same_edge", rr, {24'h0, b_bytes[0]});
            end
        join
        bus_read(CON, r);  check("pop_push_no_ovr", r, 32'h1);
        for (int i = 1; i <= DEPTH; i++) begin
            bus_read(RXD, r);
            check("pop_push_drain", r, {24'h0, b_bytes[i]});
        end

        // Framing error, long break, then a good frame.
        send_frame(8'h3C, 1'b0);
        drive_line(1'b0, 200);
        bus_read(CON, r);  check("ferr_con", r, 32'h4);
        drive_line(1'b1, 2 * CPB);
        send_frame(8'h5A, 1'b1);
        bus_read(CON, r);  check("after_ferr_con", r, 32'h5);
        bus_read(RXD, r);  check("after_ferr_rxd", r, 32'h5A);
        bus_write(CON, 32'h4);
        bus_read(CON, r);  check("ferr_cleared", r, 32'h0);

        // Glitch shorter than half a bit.
        drive_line(1'b0, 4);
        drive_line(1'b1, 4 * CPB);
        bus_read(CON, r);  check("glitch_con", r, 32'h0);

        // Interrupt enable and release by reading RXD.
        bus_write(CON, 32'h8);
        expect_irq("irq_enabled_empty", 1'b0);
        send_frame(8'h7E, 1'b1);
        expect_irq("irq_raised", 1'b1);
        bus_read(CON, r);  check("irq_con", r, 32'h9);
        bus_read(RXD, r);  check("irq_rxd", r, 32'h7E);
        expect_irq("irq_dropped", 1'b0);

        // Reset in the middle of data bit 3, line still low on release.
        drive_line(1'b0, 4 * CPB + CPB / 2);
        #1 reset = 1'b0;
        @(negedge sysclk) check("mid_reset_irq", {31'h0, rx_irq}, 32'h0);
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b1;
        drive_line(1'b0, 12 * CPB);
        bus_read(CON, r);  check("post_reset_low_con", r, 32'h0);
        drive_line(1'b1, 2 * CPB);
        bus_read(CON, r);  check("post_reset_con", r, 32'h0);
        send_frame(8'hC3, 1'b1);
        bus_read(CON, r);  check("post_reset_frame_con", r, 32'h1);
        bus_read(RXD, r);  check("post_reset_frame_rxd", r, 32'hC3);
        repeat (4) @(posedge sysclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
